uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial UART receiver for the peripheral/uart block: 8N1 frames, LSB first.
- Consumes the single-cycle oversample tick from the UART baud generator (OVERSAMPLE_AMOUNT ticks per bit).
- Synchronises the rx pin, detects the start bit and samples mid-bit.
- Presents each byte through a ready/ack handshake with framing-error and overrun flags.

Parameters:
- OVERSAMPLE_AMOUNT, 8, ticks per bit period; even, >= 4; must match the baud generator.
- DATA_BITS, 8, data bits per frame; 5..8.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- oversample_tick  input  1  one-clk pulse at OVERSAMPLE_AMOUNT x baud
- rx  input  1  asynchronous serial line, idle high
- data  output  DATA_BITS  last good byte; LSB = first received bit
- data_ready  output  1  level; byte in data not yet acknowledged
- data_ack  input  1  one-clk pulse from consumer; clears data_ready
- framing_error  output  1  one-clk pulse; stop bit sampled 0
- overrun  output  1  one-clk pulse; good byte completed while data_ready was already 1
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync release): state=IDLE; data=0, data_ready=0, framing_error=0, overrun=0, busy=0; sync flops=1; counters=0.
- rx passes through a 2-flop synchroniser; only rx_s (second flop) is used.
- The state machine advances only on clk edges with oversample_tick=1. On all other cycles, state and counters hold.
- Sample counter: ctr, width $clog2(OVERSAMPLE_AMOUNT). Bit index: idx, width $clog2(DATA_BITS)+1.
- IDLE:
  - On a tick with rx_s=0: go to START, ctr=0.
- START:
  - On a tick with ctr != OVERSAMPLE_AMOUNT/2-1: ctr++.
  - On a tick with ctr == OVERSAMPLE_AMOUNT/2-1 (mid start bit):
    - rx_s=1: false start, return to IDLE; no flags.
    - rx_s=0: go to DATA, ctr=0, idx=0.
- DATA:
  - On a tick with ctr != OVERSAMPLE_AMOUNT-1: ctr++.
  - On a tick with ctr == OVERSAMPLE_AMOUNT-1: shift rx_s in at the MSB of the shift register (right shift, LSB-first), ctr=0.
  - If idx == DATA_BITS-1 go to STOP, else idx++.
- STOP:
  - On a tick with ctr == OVERSAMPLE_AMOUNT-1 (mid stop bit), sample rx_s, then go to IDLE the same edge:
    - rx_s=1: data <= shift register, data_ready <= 1; overrun pulses if data_ready was 1 and data_ack is not asserted this cycle.
    - rx_s=0: framing_error pulses; data and data_ready are unchanged.
- Return to IDLE happens at mid stop bit, so a start bit arriving immediately after the stop bit is still caught.
- Handshake:
  - data_ack while data_ready=1 clears data_ready next edge.
  - data_ack while data_ready=0 is ignored.
  - Byte completion and data_ack on the same edge: completion wins; data_ready stays 1, new byte loaded, no overrun.
- Latency: data_ready rises on the edge of the tick at mid stop bit, about (1 + DATA_BITS + 0.5) bit periods after the falling edge, plus 2 clk of synchroniser delay.
- busy = (state != IDLE), registered with the state.
- rst_n asserted mid-frame aborts immediately to reset values. Reception restarts only on a new falling edge seen after release; a line still low at release is taken as a start bit.

Test Plan:
All scenarios use a tick every 4 clk; bit period = 32 clk.
- Send 0xA5 with a good stop bit -> data=0xA5, data_ready=1, framing_error and overrun never 1; busy high from detection to mid stop.
- rx low for 2 ticks only (glitch), then high -> busy pulses high then returns 0 at the 4th tick; data_ready stays 0; data=0x00.
- Send 0x3C with stop bit driven 0 -> one-clk framing_error pulse; data_ready=0; data unchanged (0x00).
- Send 0x11, no ack, then 0x22 back-to-back -> overrun pulses once at the end of frame 2; data=0x22; data_ready=1.
- Send 0x11, then 0x22 with data_ack asserted on the exact completion edge -> data=0x22, data_ready=1, overrun=0.
- Assert rst_n=0 after 3 data bits of 0xFF, release with rx high, then send 0x5A -> all outputs 0 during reset; then data=0x5A, data_ready=1, no errors.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx                                                         |
// | Purpose  : 8N1 UART receiver, mid-bit sampling, ready/ack byte handshake.  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module uart_rx #(
  parameter int OVERSAMPLE_AMOUNT = 8,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 oversample_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 data_ready,
  input  logic                 data_ack,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int c_CTR_W = $clog2(OVERSAMPLE_AMOUNT);
  localparam int c_IDX_W = $clog2(DATA_BITS) + 1;
  localparam logic [c_CTR_W-1:0] c_CTR_HALF = c_CTR_W'(OVERSAMPLE_AMOUNT/2 - 1);
  localparam logic [c_CTR_W-1:0] c_CTR_FULL = c_CTR_W'(OVERSAMPLE_AMOUNT - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t               r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic [c_CTR_W-1:0]   r_ctr;
  logic [c_IDX_W-1:0]   r_idx;
  logic [DATA_BITS-1:0] r_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_ctr         <= '0;
      r_idx         <= '0;
      r_shift       <= '0;
      data          <= '0;
      data_ready    <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      busy          <= 1'b0;
    end else begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
      if (data_ack && data_ready) begin
        data_ready <= 1'b0;
      end
      if (oversample_tick) begin
        case (r_state)
          S_IDLE: begin
            if (!r_sync2) begin
              r_state <= S_START;
              r_ctr   <= '0;
              busy    <= 1'b1;
            end
          end
          S_START: begin
            if (r_ctr == c_CTR_HALF) begin
              // A line back high at mid start bit was only a glitch.
              if (r_sync2) begin
                r_state <= S_IDLE;
                busy    <= 1'b0;
              end else begin
                r_state <= S_DATA;
                r_ctr   <= '0;
                r_idx   <= '0;
              end
            end else begin
              r_ctr <= r_ctr + 1'b1;
            end
          end
          S_DATA: begin
            if (r_ctr == c_CTR_FULL) begin
              r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
              r_ctr   <= '0;
              if (r_idx == c_IDX_LAST) begin
                r_state <= S_STOP;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_ctr <= r_ctr + 1'b1;
            end
          end
          S_STOP: begin
            if (r_ctr == c_CTR_FULL) begin
              // Leave at mid stop bit so an immediately following start bit is caught.
              r_state <= S_IDLE;
              r_ctr   <= '0;
              busy    <= 1'b0;
              if (r_sync2) begin
                data       <= r_shift;
                data_ready <= 1'b1;
                overrun    <= data_ready && !data_ack;
              end else begin
                framing_error <= 1'b1;
              end
            end else begin
              r_ctr <= r_ctr + 1'b1;
            end
          end
          default: begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_rx                                                      |
// | Purpose  : Directed self-checking bench for uart_rx (tick every 4 clk).    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       oversample_tick = 1'b0;
  logic       rx;
  logic [7:0] data;
  logic       data_ready;
  logic       data_ack;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  int total = 0;
  int bad   = 0;
  int tcnt  = 3;
  int fe_cnt = 0, ov_cnt = 0, busy_cnt = 0;
  int fe0, ov0, busy0;

  uart_rx #(.OVERSAMPLE_AMOUNT(8), .DATA_BITS(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .oversample_tick(oversample_tick),
    .rx             (rx),
    .data           (data),
    .data_ready     (data_ready),
    .data_ack       (data_ack),
    .framing_error  (framing_error),
    .overrun        (overrun),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  // Baud tick: one clk high out of every four.
  always @(negedge clk) begin
    tcnt = (tcnt == 3) ? 0 : tcnt + 1;
    oversample_tick = (tcnt == 0);
  end

  always @(negedge clk) begin
    if (framing_error) fe_cnt++;
    if (overrun) ov_cnt++;
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    fe0 = fe_cnt; ov0 = ov_cnt; busy0 = busy_cnt;
  endtask

  task automatic wait_tick();
    @(posedge clk);
    while (!oversample_tick) @(posedge clk);
  endtask

  // Full 10-bit frame, 32 clk per bit; completion lands 308 clk after the
  // aligning tick, so ack_last pulses data_ack onto exactly that edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic ack_last);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    wait_tick();
    snap();
    @(negedge clk);
    for (int c = 0; c < 320; c++) begin
      rx = f[c/32];
      data_ack = ack_last && (c == 307);
      @(negedge clk);
    end
    rx = 1'b1;
    data_ack = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic ack();
    @(negedge clk);
    data_ack = 1'b1;
    @(negedge clk);
    data_ack = 1'b0;
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    rx = 1'b1;
    data_ack = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_data", {24'd0, data}, 32'h00);
    check("rst_ready", {31'd0, data_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_fe", {31'd0, framing_error}, 32'd0);
    check("rst_ov", {31'd0, overrun}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(16);

    // Glitch: 2 ticks low -> start rejected at mid start bit
    wait_tick();
    snap();
    @(negedge clk);
    rx = 1'b0;
    repeat (8) @(negedge clk);
    rx = 1'b1;
    idle(40);
    check("glitch_busy_cycles", busy_cnt - busy0, 16);
    check("glitch_busy_end", {31'd0, busy}, 32'd0);
    check("glitch_ready", {31'd0, data_ready}, 32'd0);
    check("glitch_data", {24'd0, data}, 32'h00);

    // Framing error
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(64);
    check("fe_pulses", fe_cnt - fe0, 1);
    check("fe_ready", {31'd0, data_ready}, 32'd0);
    check("fe_data", {24'd0, data}, 32'h00);
    check("fe_ov", ov_cnt - ov0, 0);

    // Good byte
    send_frame(8'hA5, 1'b1, 1'b0);
    check("a5_data", {24'd0, data}, 32'hA5);
    check("a5_ready", {31'd0, data_ready}, 32'd1);
    check("a5_busy_cycles", busy_cnt - busy0, 304);
    check("a5_fe", fe_cnt - fe0, 0);
    check("a5_ov", ov_cnt - ov0, 0);
    check("a5_busy_end", {31'd0, busy}, 32'd0);
    ack();
    check("ack_clears", {31'd0, data_ready}, 32'd0);
    ack();
    check("ack_idle_ignored", {31'd0, data_ready}, 32'd0);
    check("ack_data_kept", {24'd0, data}, 32'hA5);

    // Overrun: two frames, no ack
    send_frame(8'h11, 1'b1, 1'b0);
    check("ov1_data", {24'd0, data}, 32'h11);
    check("ov1_ov", ov_cnt - ov0, 0);
    send_frame(8'h22, 1'b1, 1'b0);
    check("ov2_data", {24'd0, data}, 32'h22);
    check("ov2_ready", {31'd0, data_ready}, 32'd1);
    check("ov2_ov", ov_cnt - ov0, 1);
    check("ov2_fe", fe_cnt - fe0, 0);
    ack();

    // Ack on the completion edge: completion wins, no overrun
    send_frame(8'h11, 1'b1, 1'b0);
    check("ak1_ready", {31'd0, data_ready}, 32'd1);
    send_frame(8'h22, 1'b1, 1'b1);
    check("ak2_data", {24'd0, data}, 32'h22);
    check("ak2_ready", {31'd0, data_ready}, 32'd1);
    check("ak2_ov", ov_cnt - ov0, 0);

    // Reset mid-frame (start + 3 data bits of 0xFF)
    wait_tick();
    @(negedge clk);
    rx = 1'b0;
    repeat (32) @(negedge clk);
    rx = 1'b1;
    repeat (96) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mrst_data", {24'd0, data}, 32'h00);
    check("mrst_ready", {31'd0, data_ready}, 32'd0);
    check("mrst_busy", {31'd0, busy}, 32'd0);
    check("mrst_fe", {31'd0, framing_error}, 32'd0);
    check("mrst_ov", {31'd0, overrun}, 32'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle(16);
    check("post_rst_busy", {31'd0, busy}, 32'd0);
    send_frame(8'h5A, 1'b1, 1'b0);
    check("5a_data", {24'd0, data}, 32'h5A);
    check("5a_ready", {31'd0, data_ready}, 32'd1);
    check("5a_fe", fe_cnt - fe0, 0);
    check("5a_ov", ov_cnt - ov0, 0);
    check("5a_busy_cycles", busy_cnt - busy0, 304);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
